bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter.sv | 115 +++++++++++
 tb/tb_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for a single shared peripheral bus.
// One access per grant, a one-cycle turnaround after each access, and a slave wait timeout.
module bus_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_write,
   input  logic          m0_read,
   input  logic [AW-1:0] m0_address,
   input  logic [DW-1:0] m0_dout,
   output logic [DW-1:0] m0_din,
   output logic          m0_ready,
   output logic          m0_err,
   input  logic          m1_write,
   input  logic          m1_read,
   input  logic [AW-1:0] m1_address,
   input  logic [DW-1:0] m1_dout,
   output logic [DW-1:0] m1_din,
   output logic          m1_ready,
   output logic          m1_err,
   output logic          s_write,
   output logic          s_read,
   output logic [AW-1:0] s_address,
   output logic [DW-1:0] s_dout,
   input  logic [DW-1:0] s_din,
   input  logic          s_ready,
   // Debug view of the FSM: 0 IDLE, 1 GRANT0, 2 GRANT1, 3 TURN
   output logic [1:0]    state_dbg
);

   // Handshake: a master raises write/read and holds it, with address and data stable,
   // until the cycle its ready is high; ready is a one-cycle completion pulse.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      TURN   = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t     state;
   logic       last_grant;
   logic [7:0] wait_cnt;

   logic req0, req1;
   logic granted, sel1;
   logic sel_write, sel_read;
   logic timed_out, done;

   assign req0 = m0_write | m0_read;
   assign req1 = m1_write | m1_read;

   // Reset gates the bus combinationally so an access in flight never completes.
   assign granted   = ((state == GRANT0) || (state == GRANT1)) && !rst;
   assign sel1      = (state == GRANT1);
   assign sel_write = sel1 ? m1_write : m0_write;
   assign sel_read  = sel1 ? m1_read  : m0_read;
   assign timed_out = granted && !s_ready && (wait_cnt == TIMEOUT_CNT);
   assign done      = granted && (s_ready || timed_out);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         wait_cnt   <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 && (!req1 || last_grant)) begin
                  state      <= GRANT0;
                  last_grant <= 1'b0;
                  wait_cnt   <= 8'd0;
               end else if (req1) begin
                  state      <= GRANT1;
                  last_grant <= 1'b1;
                  wait_cnt   <= 8'd0;
               end
            end
            GRANT0, GRANT1: begin
               if (done) state <= TURN;
               else      wait_cnt <= wait_cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      s_write   = granted && sel_write;
      s_read    = granted && sel_read && !sel_write;
      s_address = '0;
      s_dout    = '0;
      if (granted) begin
         s_address = sel1 ? m1_address : m0_address;
         s_dout    = sel1 ? m1_dout    : m0_dout;
      end
   end

   // Read data only passes on a normal completion; a timeout returns zero.
   always_comb begin
      m0_ready = done && !sel1;
      m1_ready = done && sel1;
      m0_err   = timed_out && !sel1;
      m1_err   = timed_out && sel1;
      m0_din   = (granted && !sel1 && s_ready) ? s_din : '0;
      m1_din   = (granted && sel1 && s_ready)  ? s_din : '0;
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a transaction-level model checks every output each cycle,
// and literal expectations at hand-timed cycles pin the model down.
module tb_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_write, m0_read, m1_write, m1_read;
   logic [AW-1:0] m0_address, m1_address, s_address;
   logic [DW-1:0] m0_dout, m1_dout, m0_din, m1_din, s_dout, s_din;
   logic          m0_ready, m0_err, m1_ready, m1_err;
   logic          s_write, s_read, s_ready;
   logic [1:0]    state_dbg;

   int n_vec = 0;
   int n_err = 0;

   bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_write(m0_write), .m0_read(m0_read), .m0_address(m0_address), .m0_dout(m0_dout),
      .m0_din(m0_din), .m0_ready(m0_ready), .m0_err(m0_err),
      .m1_write(m1_write), .m1_read(m1_read), .m1_address(m1_address), .m1_dout(m1_dout),
      .m1_din(m1_din), .m1_ready(m1_ready), .m1_err(m1_err),
      .s_write(s_write), .s_read(s_read), .s_address(s_address), .s_dout(s_dout),
      .s_din(s_din), .s_ready(s_ready), .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model + scoreboard ----------------
   int         mdl_owner  = -1;   // master holding the bus, -1 when free
   bit         mdl_turn   = 1'b0;
   bit         mdl_last   = 1'b1;
   int         mdl_waited = 0;
   bit         track      = 1'b0;
   logic [1:0] exp_q[$];

   logic          e_sw, e_sr, e_r0, e_r1, e_e0, e_e1, e_w, e_q0, e_q1;
   logic [AW-1:0] e_sa;
   logic [DW-1:0] e_sd, e_d0, e_d1;
   logic [1:0]    e_st, e_exp_m;

   always @(negedge clk) begin
      e_sw = 0; e_sr = 0; e_sa = '0; e_sd = '0;
      e_r0 = 0; e_r1 = 0; e_e0 = 0; e_e1 = 0; e_d0 = '0; e_d1 = '0;
      e_st = mdl_turn ? 2'd3 : (mdl_owner == 0) ? 2'd1 : (mdl_owner == 1) ? 2'd2 : 2'd0;
      if (!rst && !mdl_turn && mdl_owner >= 0) begin
         e_w  = (mdl_owner == 1) ? m1_write : m0_write;
         e_sw = e_w;
         e_sr = ((mdl_owner == 1) ? m1_read : m0_read) && !e_w;
         e_sa = (mdl_owner == 1) ? m1_address : m0_address;
         e_sd = (mdl_owner == 1) ? m1_dout : m0_dout;
         if (s_ready) begin
            if (mdl_owner == 1) begin e_r1 = 1; e_d1 = s_din; end
            else                begin e_r0 = 1; e_d0 = s_din; end
         end else if (mdl_waited == TO) begin
            if (mdl_owner == 1) begin e_r1 = 1; e_e1 = 1; end
            else                begin e_r0 = 1; e_e0 = 1; end
         end
      end
      check("s_write", s_write, e_sw);
      check("s_read", s_read, e_sr);
      check("s_address", s_address, e_sa);
      check("s_dout", s_dout, e_sd);
      check("m0_ready", m0_ready, e_r0);
      check("m1_ready", m1_ready, e_r1);
      check("m0_err", m0_err, e_e0);
      check("m1_err", m1_err, e_e1);
      check("m0_din", m0_din, e_d0);
      check("m1_din", m1_din, e_d1);
      check("state", state_dbg, e_st);
      if (track && (m0_ready || m1_ready)) begin
         e_exp_m = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd2;
         check("grant_order", {1'b0, m1_ready}, e_exp_m);
      end
      // advance the model across the coming edge
      if (rst) begin
         mdl_owner = -1; mdl_turn = 0; mdl_last = 1; mdl_waited = 0;
      end else if (mdl_turn) begin
         mdl_turn = 0;
      end else if (mdl_owner < 0) begin
         e_q0 = m0_write | m0_read;
         e_q1 = m1_write | m1_read;
         if (e_q0 && e_q1) mdl_owner = mdl_last ? 0 : 1;
         else if (e_q0)    mdl_owner = 0;
         else if (e_q1)    mdl_owner = 1;
         if (mdl_owner >= 0) begin
            mdl_last   = (mdl_owner == 1);
            mdl_waited = 0;
         end
      end else if (e_r0 || e_r1) begin
         mdl_owner = -1; mdl_turn = 1;
      end else begin
         mdl_waited++;
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      s_din = $urandom;
   endtask

   task automatic set_m0(input logic w, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m0_write = w; m0_read = r; m0_address = a; m0_dout = d;
   endtask

   task automatic set_m1(input logic w, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m1_write = w; m1_read = r; m1_address = a; m1_dout = d;
   endtask

   // Random traffic that honours the hold-until-ready rule.
   task automatic soak(input int cycles, input bit allow_new);
      logic r0, r1;
      bit   a0, a1;
      a0 = m0_write | m0_read;
      a1 = m1_write | m1_read;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         r0 = m0_ready; r1 = m1_ready;
         tick();
         if (r0) begin set_m0(0, 0, '0, '0); a0 = 0; end
         if (r1) begin set_m1(0, 0, '0, '0); a1 = 0; end
         if (allow_new && !a0 && $urandom_range(0, 1) == 1) begin
            set_m0(1'($urandom_range(0, 1)), 1'b1, $urandom, $urandom); a0 = 1;
         end
         if (allow_new && !a1 && $urandom_range(0, 1) == 1) begin
            set_m1(1'($urandom_range(0, 1)), 1'b1, $urandom, $urandom); a1 = 1;
         end
         s_ready = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   endtask

   initial begin
      rst = 1; s_ready = 0; s_din = '0;
      set_m0(0, 0, '0, '0);
      set_m1(0, 0, '0, '0);
      repeat (3) tick();
      @(negedge clk);
      check("rst_s_write", s_write, 0);
      check("rst_m0_ready", m0_ready, 0);
      tick(); rst = 0;
      @(negedge clk);
      check("post_rst_state", state_dbg, 2'd0);

      // single CPU write with the slave always ready
      tick(); s_ready = 1; set_m0(1, 0, 32'h8000_0000, 32'h5);
      @(negedge clk); check("w_t0_s_write", s_write, 0);
      tick();
      @(negedge clk);
      check("w_t1_s_write", s_write, 1);
      check("w_t1_addr", s_address, 32'h8000_0000);
      check("w_t1_dout", s_dout, 32'h5);
      check("w_t1_ready", m0_ready, 1);
      tick(); set_m0(0, 0, '0, '0);
      @(negedge clk); check("w_t2_turn", state_dbg, 2'd3);
      tick();
      @(negedge clk); check("w_t3_idle", state_dbg, 2'd0);

      // both masters reading continuously from reset: grants alternate
      tick(); rst = 1; set_m0(0, 1, 32'h100, '0); set_m1(0, 1, 32'h200, '0);
      @(negedge clk); check("rr_rst_ready", m0_ready, 0);
      tick(); rst = 0;
      exp_q.push_back(2'd0); exp_q.push_back(2'd1);
      exp_q.push_back(2'd0); exp_q.push_back(2'd1);
      track = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         @(negedge clk);
         check("rr_m0_ready", m0_ready, (k % 2 == 0));
         check("rr_m1_ready", m1_ready, (k % 2 == 1));
         check("rr_din", (k % 2 == 0) ? m0_din : m1_din, s_din);
         tick(); tick();
      end
      set_m0(0, 0, '0, '0); set_m1(0, 0, '0, '0);
      track = 0;
      check("rr_all_seen", exp_q.size(), 0);

      // master 1 read against a silent slave: timeout on the 5th granted cycle
      tick(); s_ready = 0; set_m1(0, 1, 32'h1234, '0);
      tick();
      @(negedge clk); check("to_grant", state_dbg, 2'd2);
      repeat (3) tick();
      @(negedge clk); check("to_early", m1_ready, 0);
      tick();
      @(negedge clk);
      check("to_ready", m1_ready, 1);
      check("to_err", m1_err, 1);
      check("to_din", m1_din, 0);
      tick(); set_m1(0, 0, '0, '0);
      @(negedge clk); check("to_s_read_low", s_read, 0);
      tick();

      // slave answers exactly when the counter reaches the limit
      tick(); s_ready = 0; set_m0(0, 1, 32'h44, '0);
      repeat (4) tick();
      @(negedge clk); check("race_early", m0_ready, 0);
      tick(); s_ready = 1;
      @(negedge clk);
      check("race_ready", m0_ready, 1);
      check("race_err", m0_err, 0);
      check("race_din", m0_din, s_din);
      tick(); s_ready = 0; set_m0(0, 0, '0, '0);
      tick();

      // write and read both high: write wins
      tick(); s_ready = 1; set_m0(1, 1, 32'h88, 32'hA5);
      tick();
      @(negedge clk);
      check("wr_s_write", s_write, 1);
      check("wr_s_read", s_read, 0);
      tick(); set_m0(0, 0, '0, '0);
      tick();

      // reset during a master-1 access, then contention
      tick(); s_ready = 0; set_m1(0, 1, 32'h300, '0);
      tick();
      @(negedge clk); check("ab_grant1", state_dbg, 2'd2);
      tick(); rst = 1;
      @(negedge clk); check("ab_rst_ready", m1_ready, 0);
      tick(); rst = 0; set_m0(0, 1, 32'h400, '0);
      @(negedge clk);
      check("ab_idle", state_dbg, 2'd0);
      check("ab_no_ready", m1_ready, 0);
      tick(); s_ready = 1;
      @(negedge clk);
      check("ab_m0_first", m0_ready, 1);
      check("ab_m1_wait", m1_ready, 0);
      tick(); set_m0(0, 0, '0, '0);
      tick(); tick();
      @(negedge clk); check("ab_m1_later", m1_ready, 1);
      tick(); set_m1(0, 0, '0, '0);
      tick();

      // mixed traffic, then drain with the slave always ready
      soak(120, 1'b1);
      soak(20, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
      $fatal(1);
   end

endmodule
